// File: rtl/spi_slave_rsp.sv
// SPI mode-0 slave: synchronized pins, full-duplex frame shifter, FIFO-style rx/tx handshakes.
// Latency: SYNC_STAGES+2 clk from last SCK rise to rx_valid; backpressure: none, rx_full drops the frame into sticky rx_overflow.
module spi_slave_rsp #(
    parameter int FRAME_BITS  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spi_sck,
    input  logic                  spi_cs,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  spi_miso_oe,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_full,
    input  logic [FRAME_BITS-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  rx_overflow,
    output logic                  tx_underrun,
    output logic                  frame_abort
);
    localparam int CW = $clog2(FRAME_BITS + 1);
    localparam logic [CW-1:0] LAST = CW'(FRAME_BITS);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t                  state, state_nxt;
    logic [SYNC_STAGES-1:0]  sck_sync, cs_sync, mosi_sync;
    logic                    sck_d, cs_d;
    logic [SYNC_STAGES:0]    flush;
    logic                    armed;
    logic [CW-1:0]           bit_cnt;
    logic [FRAME_BITS-1:0]   tx_shift, rx_shift;
    logic                    sck_s, cs_s, mosi_s;
    logic                    sck_rise, sck_fall, cs_fall;
    logic                    frame_done, shift_en;
    logic                    load_take, load_empty, abort;

    assign sck_s      = sck_sync[SYNC_STAGES-1];
    assign cs_s       = cs_sync[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync[SYNC_STAGES-1];
    assign sck_rise   = sck_s & ~sck_d;
    assign sck_fall   = ~sck_s & sck_d;
    assign cs_fall    = cs_d & ~cs_s;
    assign frame_done = (state == SHIFT) && (bit_cnt == LAST);
    assign shift_en   = (state == SHIFT) && !cs_s && !frame_done;

    assign spi_miso    = tx_shift[FRAME_BITS-1];
    assign spi_miso_oe = ~cs_s;
    assign tx_ready    = load_take;

    // armed needs a genuine high CS after the synchronizers flush, so a CS held
    // low across reset is not mistaken for a fresh falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sck_d     <= 1'b0;
            cs_d      <= 1'b1;
            flush     <= '0;
            armed     <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sck_d     <= sck_s;
            cs_d      <= cs_s;
            flush     <= {flush[SYNC_STAGES-1:0], 1'b1};
            if (flush[SYNC_STAGES] && cs_s) armed <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        load_take  = 1'b0;
        load_empty = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: if (armed && cs_fall) state_nxt = LOAD;
            LOAD: begin
                if (cs_s) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt  = SHIFT;
                    load_take  = tx_valid;
                    load_empty = ~tx_valid;
                end
            end
            SHIFT: begin
                if (frame_done) begin
                    state_nxt = cs_s ? IDLE : LOAD;
                end else if (cs_s) begin
                    state_nxt = IDLE;
                    abort     = (bit_cnt != '0);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt     <= '0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_abort <= 1'b0;
            rx_overflow <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            frame_abort <= abort;

            // The fall following the last rise of a frame arrives with bit_cnt
            // already back at 0 and must not shift out the freshly loaded MSB.
            if (load_take) begin
                tx_shift <= tx_data;
            end else if (load_empty) begin
                tx_shift    <= '0;
                tx_underrun <= 1'b1;
            end else if (shift_en && sck_fall && bit_cnt != '0) begin
                tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b0};
            end

            if (frame_done) begin
                rx_data <= rx_shift;
                if (rx_full) rx_overflow <= 1'b1;
                else         rx_valid    <= 1'b1;
                bit_cnt <= '0;
            end else if (state == SHIFT && cs_s) begin
                bit_cnt  <= '0;
                rx_shift <= '0;
            end else if (shift_en && sck_rise) begin
                rx_shift <= {rx_shift[FRAME_BITS-2:0], mosi_s};
                bit_cnt  <= bit_cnt + CW'(1);
            end
        end
    end
endmodule

// File: doc/spi_slave_rsp.md
SPI_SLAVE_RSP -- requirements
Module: spi_slave_rsp

Interface
REQ-001 Parameter FRAME_BITS, 32, bits per SPI frame (legal range 8..32).
REQ-002 Parameter SYNC_STAGES, 2, flops per pin synchronizer (legal range 2..3).
REQ-003 Port clk, input, 1: single system clock; every flop is clocked on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous, active-high.
REQ-005 Port spi_sck, input, 1: SPI clock from the master (mode 0, CPOL=0, CPHA=0).
REQ-006 Port spi_cs, input, 1: chip select, active-low.
REQ-007 Port spi_mosi, input, 1: master-out data, MSB first.
REQ-008 Port spi_miso, output, 1: slave-out data, MSB first.
REQ-009 Port spi_miso_oe, output, 1: MISO drive enable, high while synchronized CS is low.
REQ-010 Port rx_data, output, FRAME_BITS: last complete received frame.
REQ-011 Port rx_valid, output, 1: one-cycle pulse; rx_data is valid in that cycle (FIFO write-enable style).
REQ-012 Port rx_full, input, 1: downstream FIFO full.
REQ-013 Port tx_data, input, FRAME_BITS: next response word.
REQ-014 Port tx_valid, input, 1: tx_data is available (typically ~FIFO empty).
REQ-015 Port tx_ready, output, 1: one-cycle pulse; tx_data is consumed in that cycle (FIFO read-enable style).
REQ-016 Port rx_overflow, output, 1: sticky flag; set when a frame completes while rx_full=1.
REQ-017 Port tx_underrun, output, 1: sticky flag; set at a load point where tx_valid=0.
REQ-018 Port frame_abort, output, 1: one-cycle pulse when CS deasserts mid-frame.

Function
REQ-019 spi_sck, spi_cs and spi_mosi SHALL each pass through a SYNC_STAGES synchronizer; edges are detected on the synchronized values using one extra history flop.
REQ-020 The supported SCK frequency SHALL be at most clk/8; the block gives no guarantee above this rate.
REQ-021 States SHALL be IDLE, LOAD, SHIFT. Transitions: IDLE -> LOAD on CS falling edge; LOAD -> SHIFT after exactly one cycle; SHIFT -> LOAD when bit_cnt wraps with CS still low; any state -> IDLE on CS high.
REQ-022 LOAD: if tx_valid=1, the block SHALL pulse tx_ready and copy tx_data into the tx shift register; otherwise it SHALL load all zeros and set tx_underrun.
REQ-023 On exit from LOAD, spi_miso SHALL present tx_shift[FRAME_BITS-1]; on each synchronized SCK falling edge in SHIFT, tx_shift SHALL shift left by one bit, zero-filling.
REQ-024 On each synchronized SCK rising edge in SHIFT, the block SHALL shift the synchronized MOSI into the LSB of rx_shift and increment bit_cnt.
REQ-025 When bit_cnt reaches FRAME_BITS, on the cycle after that rising edge the block SHALL: update rx_data; pulse rx_valid if rx_full=0, else set rx_overflow with no pulse; reset bit_cnt to 0; enter LOAD for back-to-back frames.
REQ-026 Latency from the pin-level 32nd SCK rising edge to rx_valid SHALL be SYNC_STAGES+2 clk cycles.
REQ-027 A CS rise with 0 < bit_cnt < FRAME_BITS SHALL pulse frame_abort, discard the partial rx_shift and produce no rx_valid; a word already taken via tx_ready is not returned.
REQ-028 A CS rise with bit_cnt=0 (frame boundary, or no edges received) SHALL NOT pulse frame_abort.
REQ-029 SCK edges while CS is high SHALL be ignored.
REQ-030 If an SCK edge coincides with a CS rise in the same synchronized cycle, the CS rise SHALL take priority and the edge SHALL be ignored.
REQ-031 tx_ready SHALL pulse at most once per frame; rx_valid SHALL pulse at most once per frame.
REQ-032 rx_overflow and tx_underrun SHALL be cleared only by rst.

Reset
REQ-033 While rst=1, the block SHALL hold: state=IDLE, bit_cnt=0, shift registers=0, rx_data=0, rx_valid=0, tx_ready=0, frame_abort=0, rx_overflow=0, tx_underrun=0, spi_miso=0, spi_miso_oe=0, synchronizer flops at idle levels (SCK=0, CS=1, MOSI=0).
REQ-034 rst asserted mid-frame SHALL abandon the frame with no rx_valid and no frame_abort; after reset release, the block SHALL wait for a fresh CS falling edge.

Verification
REQ-035 Single frame at clk/8 SCK, MOSI=0xA5C3_0F81, tx_data=0x1234_5678, tx_valid=1 -> one tx_ready, MISO bits read 0x12345678, one rx_valid with rx_data=0xA5C30F81.
REQ-036 Two back-to-back frames under one CS, tx words 0xDEADBEEF then 0x0BADF00D, MOSI 0x1 then 0x2 -> two tx_ready pulses, MISO sequence matches, rx_valid carries 0x00000001 then 0x00000002.
REQ-037 tx_valid=0 at CS fall -> MISO sends 0x00000000, tx_underrun=1, rx still captured.
REQ-038 CS raised after 13 SCK edges -> frame_abort pulse, no rx_valid; next full frame 0xFFFF0000 received correctly.
REQ-039 rx_full=1 at frame end -> no rx_valid, rx_overflow=1 and sticky until rst, rx_data=received word.
REQ-040 rst pulsed after 20 bits -> all outputs reach REQ-033 values; a subsequent frame of 0x5A5A5A5A is received correctly.
